// File: rtl/robo_controlador.sv
// robo_controlador: left-hand wall-following robot controller.
// Samples head/left/under/barrier sensors in SENSE and issues one command
// (girar, avancar, remover) per decision; every output is registered.
// Optional watchdog on total command count: define ROBO_WATCHDOG_EN.
module robo_controlador #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REM_MAX       = 16,
  parameter int MAX_CMDS      = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        head_in,
  input  logic        left_in,
  input  logic        under_in,
  input  logic        barrier_in,
  output logic        avancar,
  output logic        girar,
  output logic        remover,
  output logic        busy,
  output logic        done,
  output logic [15:0] step_count,
  output logic        error
);

  // Shared counter must hold REM_MAX, SETTLE_CYCLES (<=15) and the turn count.
  localparam int CW = ($clog2(REM_MAX + 1) > 4) ? $clog2(REM_MAX + 1) : 4;
  localparam logic [CW-1:0] REM_MAX_C  = CW'(REM_MAX);
  localparam logic [CW-1:0] SETTLE_C   = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_M1  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(3);

  // Elaboration-time range checks on the configuration.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end
  if (REM_MAX < 1) begin : g_bad_remmax
    $error("REM_MAX must be at least 1");
  end
  if (MAX_CMDS < 1 || MAX_CMDS > 1023) begin : g_bad_maxcmds
    $error("MAX_CMDS must be 1..1023");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SENSE, S_TURN_R, S_REMOVE, S_SETTLE, S_DONE
  } state_t;

  state_t         r_state, w_state;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic           r_turned_left, w_turned_left;
  logic           r_avancar, w_avancar;
  logic           r_girar, w_girar;
  logic           r_remover, w_remover;
  logic           r_busy, w_busy;
  logic           r_done, w_done;
  logic           r_error, w_error;
  logic [15:0]    r_steps, w_steps;

`ifdef ROBO_WATCHDOG_EN
  localparam logic [9:0] WD_MAX = 10'(MAX_CMDS);
  logic [9:0] r_wd, w_wd;
  logic       w_cmd;
`endif

  // State and registered outputs; synchronous reset drops every command line.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_turned_left <= 1'b0;
      r_avancar     <= 1'b0;
      r_girar       <= 1'b0;
      r_remover     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_steps       <= '0;
`ifdef ROBO_WATCHDOG_EN
      r_wd          <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_turned_left <= w_turned_left;
      r_avancar     <= w_avancar;
      r_girar       <= w_girar;
      r_remover     <= w_remover;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_error       <= w_error;
      r_steps       <= w_steps;
`ifdef ROBO_WATCHDOG_EN
      r_wd          <= w_wd;
`endif
    end
  end

  // Next-state and next-output decision; commands default low every cycle.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_turned_left = r_turned_left;
    w_avancar     = 1'b0;
    w_girar       = 1'b0;
    w_remover     = 1'b0;
    w_done        = r_done;
    w_error       = r_error;
    w_steps       = r_steps;

    case (r_state)
      S_IDLE: begin
        if (start) w_state = S_SENSE;
      end
      S_SENSE: begin
        if (under_in) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else if (!left_in && !r_turned_left) begin
          // The pulse cycle itself is the first SETTLE cycle.
          w_girar       = 1'b1;
          w_turned_left = 1'b1;
          w_state       = S_SETTLE;
          w_cnt         = SETTLE_C;
        end else if (barrier_in) begin
          w_remover = 1'b1;
          w_state   = S_REMOVE;
          w_cnt     = CW'(1);
        end else if (!head_in) begin
          w_avancar     = 1'b1;
          w_turned_left = 1'b0;
          if (r_steps != 16'hFFFF) w_steps = r_steps + 16'd1;
          w_state       = S_SETTLE;
          w_cnt         = SETTLE_C;
        end else begin
          w_girar = 1'b1;
          w_state = S_TURN_R;
          w_cnt   = CW'(1);
        end
      end
      S_TURN_R: begin
        // Three left turns make one right turn; r_cnt counts high cycles.
        if (r_cnt < TURN_LAST) begin
          w_girar = 1'b1;
          w_cnt   = r_cnt + CW'(1);
        end else begin
          w_turned_left = 1'b0;
          w_state       = S_SETTLE;
          w_cnt         = SETTLE_M1;
        end
      end
      S_REMOVE: begin
        if (!barrier_in) begin
          w_turned_left = 1'b0;
          w_state       = S_SETTLE;
          w_cnt         = SETTLE_M1;
        end else if (r_cnt >= REM_MAX_C) begin
          w_error = 1'b1;
          w_state = S_DONE;
        end else begin
          w_remover = 1'b1;
          w_cnt     = r_cnt + CW'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state = S_SENSE;
        else             w_cnt   = r_cnt - CW'(1);
      end
      S_DONE: begin
        if (start) begin
          w_done        = 1'b0;
          w_error       = 1'b0;
          w_steps       = '0;
          w_turned_left = 1'b0;
          w_state       = S_SENSE;
        end
      end
      default: w_state = S_IDLE;
    endcase

`ifdef ROBO_WATCHDOG_EN
    // Every girar cycle, avancar pulse and REMOVE entry costs one command.
    w_cmd = w_girar | w_avancar | (r_state == S_SENSE && w_state == S_REMOVE);
    w_wd  = w_cmd ? r_wd + 10'd1 : r_wd;
    if ((r_state == S_IDLE || r_state == S_DONE) && start) w_wd = '0;
    if (r_state != S_IDLE && r_state != S_DONE && r_wd >= WD_MAX) begin
      w_avancar = 1'b0;
      w_girar   = 1'b0;
      w_remover = 1'b0;
      w_error   = 1'b1;
      w_done    = 1'b0;
      w_state   = S_DONE;
      w_wd      = r_wd;
    end
`endif

    w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
  end

  assign avancar    = r_avancar;
  assign girar      = r_girar;
  assign remover    = r_remover;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign step_count = r_steps;

endmodule
